// File: rtl/weight_read_addr_gen.sv
// Read-side address generator for the weight double buffer: walks OC1 -> reuse -> slice order.
// Optional stall-cycle counter output is enabled by defining WEIGHT_RD_STALL_CNT_EN.
module weight_read_addr_gen #(
    parameter int unsigned BANK_ADDR_WIDTH = 32,
    parameter int unsigned COUNTER_WIDTH   = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_config_en,
    input  logic [COUNTER_WIDTH-1:0]   i_config_oc1,
    input  logic [COUNTER_WIDTH-1:0]   i_config_reuse,
    input  logic [BANK_ADDR_WIDTH-1:0] i_config_slice,
    input  logic                       i_bank_ready,
    input  logic                       i_addr_ready,
    output logic [BANK_ADDR_WIDTH-1:0] o_addr,
    output logic                       o_addr_valid,
    output logic                       o_last_addr,
    output logic                       o_bank_done
`ifdef WEIGHT_RD_STALL_CNT_EN
    ,
    output logic [31:0]                o_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDone
    } state_e;

    localparam logic [COUNTER_WIDTH-1:0]   CntOne  = COUNTER_WIDTH'(1);
    localparam logic [BANK_ADDR_WIDTH-1:0] AddrOne = BANK_ADDR_WIDTH'(1);

    state_e                     r_state;
    state_e                     w_state_next;

    logic [COUNTER_WIDTH-1:0]   r_oc1;
    logic [COUNTER_WIDTH-1:0]   r_reuse;
    logic [BANK_ADDR_WIDTH-1:0] r_slice;
    logic [COUNTER_WIDTH-1:0]   w_oc1_next;
    logic [COUNTER_WIDTH-1:0]   w_reuse_next;
    logic [BANK_ADDR_WIDTH-1:0] w_slice_next;

    logic [BANK_ADDR_WIDTH-1:0] r_inner;
    logic [COUNTER_WIDTH-1:0]   r_reuse_cnt;
    logic [COUNTER_WIDTH-1:0]   r_oc1_cnt;
    logic [BANK_ADDR_WIDTH-1:0] r_base;
    logic [BANK_ADDR_WIDTH-1:0] w_inner_next;
    logic [COUNTER_WIDTH-1:0]   w_reuse_cnt_next;
    logic [COUNTER_WIDTH-1:0]   w_oc1_cnt_next;
    logic [BANK_ADDR_WIDTH-1:0] w_base_next;

    logic w_cfg_load;
    logic w_start;
    logic w_fire;
    logic w_inner_last;
    logic w_reuse_last;
    logic w_oc1_last;

    assign w_cfg_load   = (r_state == StIdle) && i_config_en;
    assign w_start      = (r_state == StIdle) && i_bank_ready;
    assign w_fire       = (r_state == StRead) && i_addr_ready;

    assign w_inner_last = (r_inner == r_slice - AddrOne);
    assign w_reuse_last = (r_reuse_cnt == r_reuse - CntOne);
    assign w_oc1_last   = (r_oc1_cnt == r_oc1 - CntOne);

    // A zero bound would make the pass infinite, so it loads as one.
    always_comb begin
        w_oc1_next   = r_oc1;
        w_reuse_next = r_reuse;
        w_slice_next = r_slice;
        if (w_cfg_load) begin
            w_oc1_next   = (i_config_oc1 == '0) ? CntOne : i_config_oc1;
            w_reuse_next = (i_config_reuse == '0) ? CntOne : i_config_reuse;
            w_slice_next = (i_config_slice == '0) ? AddrOne : i_config_slice;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_inner_next     = r_inner;
        w_reuse_cnt_next = r_reuse_cnt;
        w_oc1_cnt_next   = r_oc1_cnt;
        w_base_next      = r_base;
        case (r_state)
            StIdle: begin
                if (i_bank_ready) begin
                    w_state_next     = StRead;
                    w_inner_next     = '0;
                    w_reuse_cnt_next = '0;
                    w_oc1_cnt_next   = '0;
                    w_base_next      = '0;
                end
            end
            StRead: begin
                if (w_fire) begin
                    if (!w_inner_last) begin
                        w_inner_next = r_inner + AddrOne;
                    end else begin
                        w_inner_next = '0;
                        if (!w_reuse_last) begin
                            w_reuse_cnt_next = r_reuse_cnt + CntOne;
                        end else begin
                            w_reuse_cnt_next = '0;
                            if (!w_oc1_last) begin
                                w_oc1_cnt_next = r_oc1_cnt + CntOne;
                                w_base_next    = r_base + r_slice;
                            end else begin
                                // Counters park at zero so addr reads 0 outside READ.
                                w_oc1_cnt_next = '0;
                                w_base_next    = '0;
                                w_state_next   = StDone;
                            end
                        end
                    end
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_oc1       <= CntOne;
            r_reuse     <= CntOne;
            r_slice     <= AddrOne;
            r_inner     <= '0;
            r_reuse_cnt <= '0;
            r_oc1_cnt   <= '0;
            r_base      <= '0;
        end else begin
            r_oc1       <= w_oc1_next;
            r_reuse     <= w_reuse_next;
            r_slice     <= w_slice_next;
            r_inner     <= w_inner_next;
            r_reuse_cnt <= w_reuse_cnt_next;
            r_oc1_cnt   <= w_oc1_cnt_next;
            r_base      <= w_base_next;
        end
    end

    assign o_addr       = r_base + r_inner;
    assign o_addr_valid = (r_state == StRead);
    assign o_last_addr  = (r_state == StRead) && w_inner_last && w_reuse_last && w_oc1_last;
    assign o_bank_done  = (r_state == StDone);

`ifdef WEIGHT_RD_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_start) begin
            r_stall_cycles <= '0;
        end else if ((r_state == StRead) && !i_addr_ready && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_weight_read_addr_gen.sv
// Directed self-checking bench for weight_read_addr_gen; one task per scenario.
module tb_weight_read_addr_gen;

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 16;

    logic          clk;
    logic          rst;
    logic          config_en;
    logic [CW-1:0] config_oc1;
    logic [CW-1:0] config_reuse;
    logic [AW-1:0] config_slice;
    logic          bank_ready;
    logic          addr_ready;
    logic [AW-1:0] addr;
    logic          addr_valid;
    logic          last_addr;
    logic          bank_done;
`ifdef WEIGHT_RD_STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    int seq_2x2x4 [16] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 7, 4, 5, 6, 7};

    weight_read_addr_gen #(
        .BANK_ADDR_WIDTH(AW),
        .COUNTER_WIDTH  (CW)
    ) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_config_en   (config_en),
        .i_config_oc1  (config_oc1),
        .i_config_reuse(config_reuse),
        .i_config_slice(config_slice),
        .i_bank_ready  (bank_ready),
        .i_addr_ready  (addr_ready),
        .o_addr        (addr),
        .o_addr_valid  (addr_valid),
        .o_last_addr   (last_addr),
        .o_bank_done   (bank_done)
`ifdef WEIGHT_RD_STALL_CNT_EN
        ,
        .o_stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads config in IDLE together with bank_ready; returns one cycle into READ.
    task automatic start_pass(input logic cfg, input int oc1, input int reuse, input int slice);
        config_en    = cfg;
        config_oc1   = CW'(oc1);
        config_reuse = CW'(reuse);
        config_slice = AW'(slice);
        bank_ready   = 1'b1;
        tick();
        config_en  = 1'b0;
        bank_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (addr_valid !== 1'b0 || addr !== '0 || last_addr !== 1'b0 || bank_done !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b addr=%0d last=%b done=%b, want 0 0 0 0",
                     addr_valid, addr, last_addr, bank_done);
        end
    endtask

    task automatic test_basic();
        addr_ready = 1'b1;
        start_pass(1'b1, 2, 2, 4);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (addr_valid !== 1'b1 || addr !== AW'(seq_2x2x4[i]) || last_addr !== (i == 15)) begin
                errors++;
                $display("FAIL basic[%0d]: valid=%b addr=%0d last=%b, want 1 %0d %b",
                         i, addr_valid, addr, last_addr, seq_2x2x4[i], (i == 15));
            end
            tick();
        end
        checks++;
        if (bank_done !== 1'b1 || addr_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b valid=%b, want 1 0", bank_done, addr_valid);
        end
        tick();
        checks++;
        if (bank_done !== 1'b0 || addr_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: done=%b valid=%b, want 0 0", bank_done, addr_valid);
        end
    endtask

    task automatic test_stall();
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        addr_ready = 1'b1;
        start_pass(1'b0, 0, 0, 0);
        while (idx < 16 && cyc < 40) begin
            cyc++;
            addr_ready = !(cyc >= 3 && cyc <= 5);
            checks++;
            if (addr_valid !== 1'b1 || addr !== AW'(seq_2x2x4[idx]) || last_addr !== (idx == 15)) begin
                errors++;
                $display("FAIL stall[c%0d]: valid=%b addr=%0d last=%b, want 1 %0d %b",
                         cyc, addr_valid, addr, last_addr, seq_2x2x4[idx], (idx == 15));
            end
            tick();
            if (addr_ready) idx++;
        end
        addr_ready = 1'b1;
        checks++;
        if (cyc !== 19 || bank_done !== 1'b1) begin
            errors++;
            $display("FAIL stall_len: read cycles=%0d done=%b, want 19 1", cyc, bank_done);
        end
`ifdef WEIGHT_RD_STALL_CNT_EN
        checks++;
        if (stall_cycles !== 32'd3) begin
            errors++;
            $display("FAIL stall_cnt: got %0d want 3", stall_cycles);
        end
`endif
        tick();
`ifdef WEIGHT_RD_STALL_CNT_EN
        checks++;
        if (stall_cycles !== 32'd3) begin
            errors++;
            $display("FAIL stall_cnt_hold: got %0d want 3", stall_cycles);
        end
`endif
    endtask

    task automatic test_zero_cfg();
        addr_ready = 1'b1;
        start_pass(1'b1, 0, 0, 0);
        checks++;
        if (addr_valid !== 1'b1 || addr !== '0 || last_addr !== 1'b1) begin
            errors++;
            $display("FAIL zero_cfg: valid=%b addr=%0d last=%b, want 1 0 1",
                     addr_valid, addr, last_addr);
        end
        tick();
        checks++;
        if (bank_done !== 1'b1 || addr_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_cfg_done: done=%b valid=%b, want 1 0", bank_done, addr_valid);
        end
        tick();
    endtask

    task automatic test_rst_mid();
        addr_ready = 1'b1;
        start_pass(1'b1, 2, 2, 4);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (addr !== AW'(1) || addr_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: addr=%0d valid=%b, want 1 1", addr, addr_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (addr_valid !== 1'b0 || bank_done !== 1'b0 || addr !== '0) begin
            errors++;
            $display("FAIL rst_mid: valid=%b done=%b addr=%0d, want 0 0 0",
                     addr_valid, bank_done, addr);
        end
        start_pass(1'b0, 0, 0, 0);
        checks++;
        if (addr_valid !== 1'b1 || addr !== '0 || last_addr !== 1'b1) begin
            errors++;
            $display("FAIL rst_restart: valid=%b addr=%0d last=%b, want 1 0 1",
                     addr_valid, addr, last_addr);
        end
        tick();
        checks++;
        if (bank_done !== 1'b1) begin
            errors++;
            $display("FAIL rst_restart_done: done=%b want 1", bank_done);
        end
        tick();
    endtask

    task automatic test_cfg_ignored();
        int n;
        int guard;
        int last_seen;
        addr_ready = 1'b1;
        start_pass(1'b1, 1, 1, 2);
        config_en  = 1'b1;
        config_oc1 = CW'(3);
        n = 0;
        guard = 0;
        while (bank_done !== 1'b1 && guard < 50) begin
            if (addr_valid && addr_ready) n++;
            tick();
            guard++;
        end
        config_en = 1'b0;
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL cfg_ignored: handshakes=%0d want 2", n);
        end
        tick();
        config_en    = 1'b1;
        config_oc1   = CW'(3);
        config_reuse = CW'(1);
        config_slice = AW'(2);
        tick();
        config_en = 1'b0;
        start_pass(1'b0, 0, 0, 0);
        n = 0;
        guard = 0;
        last_seen = -1;
        while (bank_done !== 1'b1 && guard < 50) begin
            if (addr_valid && addr_ready) begin
                n++;
                if (last_addr) last_seen = int'(addr);
            end
            tick();
            guard++;
        end
        checks++;
        if (n !== 6 || last_seen !== 5) begin
            errors++;
            $display("FAIL cfg_applied: handshakes=%0d last addr=%0d, want 6 5", n, last_seen);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int dones;
        dones = 0;
        addr_ready   = 1'b1;
        config_en    = 1'b1;
        config_oc1   = CW'(1);
        config_reuse = CW'(1);
        config_slice = AW'(2);
        bank_ready   = 1'b1;
        tick();
        config_en = 1'b0;
        for (int k = 0; k < 12; k++) begin
            logic exp_valid;
            logic exp_done;
            exp_valid = (k % 4) < 2;
            exp_done  = (k % 4) == 2;
            if (bank_done) dones++;
            checks++;
            if (addr_valid !== exp_valid || bank_done !== exp_done ||
                (exp_valid && (addr !== AW'(k % 4) || last_addr !== ((k % 4) == 1)))) begin
                errors++;
                $display("FAIL b2b[%0d]: valid=%b done=%b addr=%0d last=%b, want %b %b %0d %b",
                         k, addr_valid, bank_done, addr, last_addr, exp_valid, exp_done,
                         k % 4, ((k % 4) == 1));
            end
            if (k == 11) bank_ready = 1'b0;
            tick();
        end
        checks++;
        if (dones !== 3) begin
            errors++;
            $display("FAIL b2b_dones: got %0d want 3", dones);
        end
    endtask

    initial begin
        rst          = 1'b1;
        config_en    = 1'b0;
        config_oc1   = '0;
        config_reuse = '0;
        config_slice = '0;
        bank_ready   = 1'b0;
        addr_ready   = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_zero_cfg();
        test_rst_mid();
        test_cfg_ignored();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
